// File: rtl/serdiv_multibit_if.sv
// -----------------------------------------------------------------------------
// serdiv_multibit_if
// Handshake bundle between the operand issue stage and the serial divider.
//
//   id_i      transaction ID of the incoming op
//   op_a_i    dividend
//   op_b_i    divisor
//   opcode_i  0 udiv, 1 div, 2 urem, 3 rem
//   word_i    32-bit word op (only meaningful for WIDTH=64)
//   in_vld_i  input valid            in_rdy_o   input ready
//   flush_i   abort the current op
//   out_vld_o result valid           out_rdy_i  result accepted
//   id_o      ID of the result       res_o      quotient or remainder
//
// Modports: master = issue side, slave = divider.
// -----------------------------------------------------------------------------
interface serdiv_multibit_if #(
   parameter int unsigned WIDTH   = 64,
   parameter int unsigned ID_BITS = 3
);
   logic [ID_BITS-1:0] id_i;
   logic [WIDTH-1:0]   op_a_i;
   logic [WIDTH-1:0]   op_b_i;
   logic [1:0]         opcode_i;
   logic               word_i;
   logic               in_vld_i;
   logic               in_rdy_o;
   logic               flush_i;
   logic               out_vld_o;
   logic               out_rdy_i;
   logic [ID_BITS-1:0] id_o;
   logic [WIDTH-1:0]   res_o;

   modport master (
      output id_i, op_a_i, op_b_i, opcode_i, word_i, in_vld_i, flush_i, out_rdy_i,
      input  in_rdy_o, out_vld_o, id_o, res_o
   );

   modport slave (
      input  id_i, op_a_i, op_b_i, opcode_i, word_i, in_vld_i, flush_i, out_rdy_i,
      output in_rdy_o, out_vld_o, id_o, res_o
   );
endinterface

// File: rtl/serdiv_multibit.sv
// -----------------------------------------------------------------------------
// serdiv_multibit
// Iterative integer divider retiring RADIX_BITS quotient bits per cycle.
// The divisor is pre-aligned to the dividend with a leading-zero count, so an
// op takes floor(n/RADIX_BITS)+1 divide cycles, n = lzc(|b|) - lzc(|a|).
// Division by zero, signed division by -1 and |a| < |b| finish in one cycle.
//
// Parameters: WIDTH (32 or 64), RADIX_BITS (1, 2 or 4), ID_BITS.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     serdiv_multibit_if.slave (operands, valid/ready in, flush,
//           valid/ready out, result ID and result)
//
// Optional feature: define SERDIV_WORD_OPS_EN to enable 32-bit word ops
// (word_i). Without it word_i is ignored and all ops are WIDTH bits wide.
// -----------------------------------------------------------------------------

// Leading-zero counter; returns WIDTH for an all-zero input.
module serdiv_multibit_lzc #(
   parameter  int unsigned WIDTH = 64,
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] in_i,
   output logic [CNT_W-1:0] cnt_o
);
   // NOTE: every signal written in always_comb gets a default first so no
   // path can leave it unassigned, which would infer a latch.
   always_comb begin
      cnt_o = CNT_W'(WIDTH);
      // Later (higher) set bits overwrite earlier ones: the MSB-most one wins.
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (in_i[i]) cnt_o = CNT_W'(int'(WIDTH) - 1 - i);
      end
   end
endmodule

module serdiv_multibit #(
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned RADIX_BITS = 2,
   parameter int unsigned ID_BITS    = 3
) (
   input logic               clk_i,
   input logic               rst_ni,
   serdiv_multibit_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH);   // shift / iteration count width
   localparam int unsigned LW = CW + 1;          // lzc result width

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DIVIDE = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   logic [1:0]         state_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   rem_q;      // partial remainder (or special-case remainder)
   logic [WIDTH-1:0]   div_q;      // aligned divisor, shifts right each step
   logic [WIDTH-1:0]   quo_q;      // quotient (or special-case quotient)
   logic               q_sign_q;
   logic               r_sign_q;
   logic               rem_op_q;
   logic               special_q;
   logic [ID_BITS-1:0] id_q;
   logic [WIDTH-1:0]   res_q;

   // ---------------------------------------------------------------------------
   // Operand conditioning
   // ---------------------------------------------------------------------------
   logic             sgn_op;
   logic [WIDTH-1:0] a_ext, b_ext;

   assign sgn_op = bus.opcode_i[0];

`ifdef SERDIV_WORD_OPS_EN
   logic word_op;
   logic word_q;

   function automatic logic [WIDTH-1:0] ext32(input logic [31:0] v, input logic sgn);
      logic [WIDTH-1:0] r;
      r       = (sgn && v[31]) ? '1 : '0;
      r[31:0] = v;
      return r;
   endfunction

   assign word_op = bus.word_i & (WIDTH == 64);
   // Word ops run on the full datapath with 32-bit-extended operands; the
   // lzc difference is identical to one taken over 32 bits.
   assign a_ext   = word_op ? ext32(bus.op_a_i[31:0], sgn_op) : bus.op_a_i;
   assign b_ext   = word_op ? ext32(bus.op_b_i[31:0], sgn_op) : bus.op_b_i;
`else
   logic unused_word;
   assign unused_word = bus.word_i;
   assign a_ext       = bus.op_a_i;
   assign b_ext       = bus.op_b_i;
`endif

   logic             a_sgn, b_sgn;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [LW-1:0]    lzc_a, lzc_b;
   logic             n_neg;
   logic [CW-1:0]    n_u;
   logic             b_zero, b_m1, special_in;

   assign a_sgn = sgn_op & a_ext[WIDTH-1];
   assign b_sgn = sgn_op & b_ext[WIDTH-1];
   assign a_abs = a_sgn ? -a_ext : a_ext;
   assign b_abs = b_sgn ? -b_ext : b_ext;

   serdiv_multibit_lzc #(.WIDTH(WIDTH)) u_lzc_a (.in_i(a_abs), .cnt_o(lzc_a));
   serdiv_multibit_lzc #(.WIDTH(WIDTH)) u_lzc_b (.in_i(b_abs), .cnt_o(lzc_b));

   assign n_neg      = lzc_b < lzc_a;
   assign n_u        = CW'(lzc_b - lzc_a);
   assign b_zero     = (b_ext == '0);
   assign b_m1       = sgn_op & (&b_ext);
   assign special_in = b_zero | b_m1 | n_neg;

   // ---------------------------------------------------------------------------
   // Iteration: up to RADIX_BITS chained compare/subtract steps per cycle
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] rem_nxt, div_nxt, quo_nxt;
   logic             last_iter;

   // NOTE: blocking assignments inside always_comb chain each step onto the
   // previous one within the same cycle.
   always_comb begin
      rem_nxt = rem_q;
      div_nxt = div_q;
      quo_nxt = quo_q;
      for (int k = 0; k < int'(RADIX_BITS); k++) begin
         // Only the remaining count+1 quotient bits are produced.
         if (k <= int'(cnt_q)) begin
            if (rem_nxt >= div_nxt) begin
               rem_nxt = rem_nxt - div_nxt;
               quo_nxt = {quo_nxt[WIDTH-2:0], 1'b1};
            end else begin
               quo_nxt = {quo_nxt[WIDTH-2:0], 1'b0};
            end
            div_nxt = div_nxt >> 1;
         end
      end
   end

   assign last_iter = cnt_q < CW'(RADIX_BITS);

   // ---------------------------------------------------------------------------
   // Result fix-up (special cases already hold their final values)
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] quo_fix, rem_fix, res_sel, res_fix;

   assign quo_fix = q_sign_q ? -quo_nxt : quo_nxt;
   assign rem_fix = r_sign_q ? -rem_nxt : rem_nxt;
   assign res_sel = special_q ? (rem_op_q ? rem_q : quo_q)
                              : (rem_op_q ? rem_fix : quo_fix);
`ifdef SERDIV_WORD_OPS_EN
   assign res_fix = word_q ? ext32(res_sel[31:0], 1'b1) : res_sel;
`else
   assign res_fix = res_sel;
`endif

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         div_q     <= '0;
         quo_q     <= '0;
         q_sign_q  <= 1'b0;
         r_sign_q  <= 1'b0;
         rem_op_q  <= 1'b0;
         special_q <= 1'b0;
         id_q      <= '0;
         res_q     <= '0;
`ifdef SERDIV_WORD_OPS_EN
         word_q    <= 1'b0;
`endif
      end else if (bus.flush_i) begin
         state_q <= IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_vld_i) begin
                  state_q   <= DIVIDE;
                  cnt_q     <= special_in ? '0 : n_u;
                  div_q     <= b_abs << n_u;
                  rem_q     <= b_m1 ? '0 : (special_in ? a_ext : a_abs);
                  quo_q     <= b_zero ? '1 : (b_m1 ? -a_ext : '0);
                  q_sign_q  <= a_sgn ^ b_sgn;
                  r_sign_q  <= a_sgn;
                  rem_op_q  <= bus.opcode_i[1];
                  special_q <= special_in;
                  id_q      <= bus.id_i;
`ifdef SERDIV_WORD_OPS_EN
                  word_q    <= word_op;
`endif
               end
            end
            DIVIDE: begin
               if (special_q || last_iter) begin
                  res_q   <= res_fix;
                  state_q <= FINISH;
               end else begin
                  rem_q <= rem_nxt;
                  div_q <= div_nxt;
                  quo_q <= quo_nxt;
                  cnt_q <= cnt_q - CW'(RADIX_BITS);
               end
            end
            FINISH: begin
               if (bus.out_rdy_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_rdy_o  = (state_q == IDLE)   & ~bus.flush_i;
   assign bus.out_vld_o = (state_q == FINISH) & ~bus.flush_i;
   assign bus.id_o      = id_q;
   assign bus.res_o     = res_q;

endmodule
